decode_scoreboard_ctrl: RTL and testbench

- Issue controller between the decode stage and execute.
- Tracks registers with an outstanding long-latency writer (loads, multi-cycle mul/div) in a 32-entry pending scoreboard.
- Gates the decoded instruction with a ready/stall handshake and sequences the single shared multi-cycle unit (MDU) through an IDLE/BUSY/DONE state machine.
- Short-latency ALU results are covered by forwarding and are not tracked.

---
 rtl/decode_scoreboard_ctrl.sv | 130 +++++++++++++
 tb/tb_decode_scoreboard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard_ctrl.sv
// Decode-to-execute issue controller: pending-writer scoreboard, hazard stall and MDU sequencing.
// Define SCOREBOARD_WB_BYPASS_EN to let same-cycle writebacks unblock dependent instructions.
module decode_scoreboard_ctrl #(
    parameter int NREG    = 32,
    parameter int MDU_LAT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid,
    input  logic [4:0]      dec_ra1,
    input  logic [4:0]      dec_ra2,
    input  logic            dec_use1,
    input  logic            dec_use2,
    input  logic [4:0]      dec_dst,
    input  logic            dec_wen,
    input  logic            dec_load,
    input  logic            dec_multi,
    input  logic            wb_valid,
    input  logic [4:0]      wb_dst,
    input  logic            flush,
    output logic            issue_ready,
    output logic            stall,
    output logic            mdu_start,
    output logic            mdu_done,
    output logic [4:0]      mdu_dst,
    output logic            mdu_busy,
    output logic [NREG-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [4:0]      mdu_dst_q, mdu_dst_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [NREG-1:0] clr_vec, set_vec, hazard_vec;
    logic            raw1, raw2, waw, mdu_block;
    logic            fire, start;

    // Registers whose writer completes this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        clr_vec = '0;
        if (wb_valid)
            clr_vec[wb_dst] = 1'b1;
        if (state_q == ST_DONE)
            clr_vec[mdu_dst_q] = 1'b1;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign hazard_vec = pending_q & ~clr_vec;
`else
    assign hazard_vec = pending_q;
`endif

    always_comb begin
        raw1        = dec_use1 && (dec_ra1 != 5'd0) && hazard_vec[dec_ra1];
        raw2        = dec_use2 && (dec_ra2 != 5'd0) && hazard_vec[dec_ra2];
        waw         = dec_wen  && (dec_dst != 5'd0) && hazard_vec[dec_dst];
        mdu_block   = dec_multi && (state_q != ST_IDLE);
        issue_ready = !(raw1 || raw2 || waw || mdu_block || flush);
        fire        = dec_valid && issue_ready;
        start       = fire && dec_multi;
    end

    always_comb begin
        set_vec = '0;
        if (fire && dec_wen && (dec_dst != 5'd0) && (dec_load || dec_multi))
            set_vec[dec_dst] = 1'b1;
        // Set is applied after clear so a same-cycle set of the same register wins.
        pending_d = flush ? '0 : ((pending_q & ~clr_vec) | set_vec);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mdu_dst_d = mdu_dst_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_BUSY;
                    count_d   = 8'(MDU_LAT - 1);
                    mdu_dst_d = dec_dst;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1)
                        state_d = ST_DONE;
                end
            end
            // The DONE result predates any redirect, so it completes even under flush.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the scoreboard is
    // a flop vector, so resetting it costs nothing and makes x0 and flush clean.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 8'd0;
            mdu_dst_q <= 5'd0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mdu_dst_q <= mdu_dst_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        mdu_start = start;
        mdu_busy  = (state_q != ST_IDLE);
        mdu_done  = (state_q == ST_DONE);
        mdu_dst   = mdu_dst_q;
        pending   = pending_q;
        stall     = dec_valid && !issue_ready;
    end

endmodule

// File: tb/tb_decode_scoreboard_ctrl.sv
// Directed self-checking bench for decode_scoreboard_ctrl with MDU_LAT=8.
module tb_decode_scoreboard_ctrl;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_use1, dec_use2, dec_wen, dec_load, dec_multi;
    logic [4:0]  dec_ra1, dec_ra2, dec_dst;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        flush;
    logic        issue_ready, stall, mdu_start, mdu_done, mdu_busy;
    logic [4:0]  mdu_dst;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;
    int n_done;
    logic seen_done;

    always #5 clk = ~clk;

    decode_scoreboard_ctrl #(.NREG(32), .MDU_LAT(8)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_dst(dec_dst),
        .dec_wen(dec_wen), .dec_load(dec_load), .dec_multi(dec_multi),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
        .issue_ready(issue_ready), .stall(stall), .mdu_start(mdu_start),
        .mdu_done(mdu_done), .mdu_dst(mdu_dst), .mdu_busy(mdu_busy),
        .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic mul, input logic [4:0] dst,
                         input logic wen, input logic [4:0] ra1, input logic u1,
                         input logic [4:0] ra2, input logic u2);
        dec_valid = v;   dec_load = ld;  dec_multi = mul;
        dec_dst   = dst; dec_wen  = wen;
        dec_ra1   = ra1; dec_use1 = u1;
        dec_ra2   = ra2; dec_use2 = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b0;
        wb_dst   = 5'd0;
        flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        tick(); tick();
        check("rst_pending", pending, 32'h0);
        check("rst_busy", mdu_busy, 1'b0);
        check("rst_done", mdu_done, 1'b0);
        check("rst_start", mdu_start, 1'b0);
        check("rst_dst", mdu_dst, 5'd0);
        check("rst_ready", issue_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        reset = 1'b1;
        tick();

        // Load-use: load x5, then add reading x5.
        drive(1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("ld5_ready", issue_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); #1;
        check("ld5_pending", pending, 32'h0000_0020);
        check("lu_ready", issue_ready, 1'b0);
        check("lu_stall", stall, 1'b1);
        tick(); #1;
        check("lu_hold", issue_ready, 1'b0);
        wb_valid = 1'b1; wb_dst = 5'd5; #1;
        check("lu_wb_cycle", issue_ready, BYP);
        tick();
        wb_valid = 1'b0; #1;
        check("lu_after_wb", issue_ready, 1'b1);
        check("lu_pending_clr", pending, 32'h0);
        tick(); idle();

        // x0 immunity and unused-source masking.
        drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1); #1;
        check("x0_pending", pending, 32'h0);
        check("x0_ready", issue_ready, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0); #1;
        check("nouse2_ready", issue_ready, 1'b1);
        dec_use2 = 1'b1; #1;
        check("raw2_ready", issue_ready, 1'b0);
        dec_valid = 1'b0;
        wb_valid = 1'b1; wb_dst = 5'd4;
        tick(); idle(); #1;
        check("x4_clr", pending, 32'h0);

        // Same-cycle set and clear of x13: set wins.
        drive(1'b1, 1'b1, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_dst = 5'd13;
        tick(); idle(); #1;
        check("set_wins", pending, 32'h0000_2000);
        wb_valid = 1'b1; wb_dst = 5'd13;
        tick(); idle(); #1;
        check("x13_clr", pending, 32'h0);

        // MDU latency: mul x7, second mul presented two cycles later.
        drive(1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("mul7_start", mdu_start, 1'b1);
        tick(); idle(); #1;
        check("mul7_busy", mdu_busy, 1'b1);
        check("mul7_pending", pending, 32'h0000_0080);
        check("mul7_start_pulse", mdu_start, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("mul8_blocked", issue_ready, 1'b0);
        check("mul8_stall", stall, 1'b1);
        for (int k = 3; k <= 7; k++) begin
            tick();
            check("mul7_no_early_done", mdu_done, 1'b0);
            check("mul8_held", issue_ready, 1'b0);
        end
        tick();
        check("mul7_done", mdu_done, 1'b1);
        check("mul7_dst", mdu_dst, 5'd7);
        check("mul7_busy_done", mdu_busy, 1'b1);
        check("mul8_held_done", issue_ready, 1'b0);
        tick();
        check("mul7_idle", mdu_busy, 1'b0);
        check("mul7_pending_clr", pending, 32'h0);
        check("mul8_ready", issue_ready, 1'b1);
        check("mul8_start", mdu_start, 1'b1);
        n_done = 0; seen_done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(); idle(); #1;
            if (mdu_done && !seen_done) begin
                seen_done = 1'b1;
                n_done = i;
            end
        end
        check("mul8_latency", n_done, 8);
        check("mul8_pending_clr", pending, 32'h0);

        // Flush in BUSY, with a load presented in the flush cycle.
        drive(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("mul9_start", mdu_start, 1'b1);
        tick(); idle();
        tick(); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1; #1;
        check("flush_ready", issue_ready, 1'b0);
        check("flush_pend_before", pending, 32'h0000_0200);
        tick(); idle(); #1;
        check("flush_busy_idle", mdu_busy, 1'b0);
        check("flush_busy_pending", pending, 32'h0);
        seen_done = mdu_done;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mdu_done) seen_done = 1'b1;
        end
        check("flush_busy_no_done", seen_done, 1'b0);

        // Flush coincident with mdu_done.
        drive(1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        for (int i = 0; i < 8; i++) begin
            tick(); idle();
        end
        #1;
        check("fd_done", mdu_done, 1'b1);
        flush = 1'b1; #1;
        check("fd_done_flush", mdu_done, 1'b1);
        tick(); idle(); #1;
        check("fd_idle", mdu_busy, 1'b0);
        check("fd_no_repeat", mdu_done, 1'b0);
        check("fd_pending", pending, 32'h0);

        // Reset during BUSY.
        drive(1'b1, 1'b0, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        tick(); idle();
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rb_pending", pending, 32'h0);
        check("rb_busy", mdu_busy, 1'b0);
        check("rb_done", mdu_done, 1'b0);
        check("rb_dst", mdu_dst, 5'd0);
        check("rb_start", mdu_start, 1'b0);
        reset = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mdu_done) seen_done = 1'b1;
        end
        check("rb_no_done", seen_done, 1'b0);

        // WAW: load x3 pending, then addi writing x3.
        drive(1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("waw_ready", issue_ready, 1'b0);
        tick();
        check("waw_hold", issue_ready, 1'b0);
        wb_valid = 1'b1; wb_dst = 5'd3; #1;
        check("waw_wb_cycle", issue_ready, BYP);
        tick();
        wb_valid = 1'b0; #1;
        check("waw_after_wb", issue_ready, 1'b1);
        tick(); idle(); #1;
        check("waw_pending", pending, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
